// File: rtl/robot_motor_drive.sv
// Turns one advance/rotate decision into a fixed burst of wave-drive steps for two steppers.
// Optional `ROBOT_MOTOR_HOLD_EN: keep the last coil pattern energised while idle.
module robot_motor_drive #(
    parameter int STEP_DIV  = 50000,
    parameter int FWD_STEPS = 4,
    parameter int ROT_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       r,
    output logic [3:0] coil_l,
    output logic [3:0] coil_r,
    output logic       busy,
    output logic       move_done,
    output logic       conflict
);
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {IDLE, FWD, ROT, DONE} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div;
    logic [7:0]       count;
    logic [1:0]       idx_l, idx_r, idx_l_nxt, idx_r_nxt;
    logic             moving, step, last;
    logic [3:0]       coil_l_nxt, coil_r_nxt;
    logic             busy_nxt, done_nxt;

    function automatic logic [3:0] phase(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign moving = (state == FWD) || (state == ROT);
    assign step   = moving && (div == DIV_W'(STEP_DIV - 1));
    assign last   = step && (count == 8'd1);

    // Right motor is mounted mirrored: counting down drives it forward.
    assign idx_l_nxt = idx_l + {1'b0, step};
    assign idx_r_nxt = (state == FWD) ? idx_r - {1'b0, step} : idx_r + {1'b0, step};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div      <= '0;
            count    <= '0;
            idx_l    <= '0;
            idx_r    <= '0;
            conflict <= 1'b0;
        end else begin
            state <= state_nxt;
            idx_l <= idx_l_nxt;
            idx_r <= idx_r_nxt;
            case (state)
                IDLE: begin
                    div      <= '0;
                    count    <= r ? 8'(ROT_STEPS) : (a ? 8'(FWD_STEPS) : 8'd0);
                    conflict <= conflict | (a & r);
                end
                FWD, ROT: begin
                    div <= step ? '0 : div + DIV_W'(1);
                    if (step)
                        count <= count - 8'd1;
                end
                default: div <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (r) state_nxt = ROT;
                      else if (a) state_nxt = FWD;
            FWD, ROT: if (last) state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they can be registered without lag.
    always_comb begin
`ifdef ROBOT_MOTOR_HOLD_EN
        coil_l_nxt = coil_l;
        coil_r_nxt = coil_r;
`else
        coil_l_nxt = 4'b0000;
        coil_r_nxt = 4'b0000;
`endif
        if (state_nxt != IDLE) begin
            coil_l_nxt = phase(idx_l_nxt);
            coil_r_nxt = phase(idx_r_nxt);
        end
        busy_nxt = (state_nxt == FWD) || (state_nxt == ROT);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coil_l    <= 4'b0000;
            coil_r    <= 4'b0000;
            busy      <= 1'b0;
            move_done <= 1'b0;
        end else begin
            coil_l    <= coil_l_nxt;
            coil_r    <= coil_r_nxt;
            busy      <= busy_nxt;
            move_done <= done_nxt;
        end
    end
endmodule
